// File: rtl/exec_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exec_pkg : shared types and constants for the execution sequencer     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

endpackage
`default_nettype wire

// File: rtl/exec_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exec_controller_if : board/core signals seen by the sequencer         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface exec_controller_if;

    logic        step_btn;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        cpu_en;
    logic        running;
    logic        halted;
    logic [31:0] retired;

    modport master (
        output step_btn, run_sw, bp_en, bp_addr, pc, instr,
        input  cpu_en, running, halted, retired
    );

    modport slave (
        input  step_btn, run_sw, bp_en, bp_addr, pc, instr,
        output cpu_en, running, halted, retired
    );

endinterface
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | debounce : 2-FF sync, stability counter, one-cycle rising-edge pulse  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;

    assign w_mismatch = (r_sync2 != r_level);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (w_mismatch) begin
                // Level flips on the last of the consecutive mismatch cycles;
                // the pulse is raised in step only for a 0->1 flip.
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_pulse <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/exec_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exec_controller : core clock-enable sequencer (step / run / halt)     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module exec_controller
    import exec_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000
) (
    input  logic           clk,
    input  logic           reset,
    exec_controller_if.slave bus
);

    localparam int             DIV_W    = $clog2(RUN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic             r_run_s1;
    logic             r_run_s2;
    logic             w_step_pulse;
    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_cpu_en;
    logic             w_issue;
    logic [31:0]      r_retired;
    logic             w_tick;
    logic             w_stop;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.step_btn),
        .pulse (w_step_pulse)
    );

    assign w_tick = (r_div == DIV_LAST);
    assign w_stop = (bus.bp_en && (bus.pc == bus.bp_addr)) || (bus.instr == EBREAK_INSTR);

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_div_next   = '0;
        case (r_state)
            IDLE: begin
                if (r_run_s2) begin
                    w_state_next = RUN;
                end else if (w_step_pulse) begin
                    w_issue = 1'b1;
                end
            end
            RUN: begin
                if (!r_run_s2) begin
                    w_state_next = IDLE;
                end else if (w_tick) begin
                    if (w_stop) begin
                        w_state_next = HALT;
                    end else begin
                        w_issue = 1'b1;
                    end
                end else begin
                    w_div_next = r_div + DIV_ONE;
                end
            end
            HALT: begin
                // A step here retires the stopping instruction, then resumes.
                if (!r_run_s2) begin
                    w_state_next = IDLE;
                end else if (w_step_pulse) begin
                    w_issue      = 1'b1;
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_state   <= IDLE;
            r_div     <= '0;
            r_cpu_en  <= 1'b0;
            r_retired <= 32'd0;
        end else begin
            r_run_s1  <= bus.run_sw;
            r_run_s2  <= r_run_s1;
            r_state   <= w_state_next;
            r_div     <= w_div_next;
            r_cpu_en  <= w_issue;
            r_retired <= r_retired + {31'd0, r_cpu_en};
        end
    end

    assign bus.cpu_en  = r_cpu_en;
    assign bus.running = (r_state == RUN);
    assign bus.halted  = (r_state == HALT);
    assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_exec_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_exec_controller : directed vector bench for exec_controller        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_exec_controller;

    localparam int          DEB = 4;
    localparam int          DIV = 3;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] EBK = 32'h00100073;
    localparam logic [31:0] BPA = 32'h0000000C;

    logic clk = 1'b0;
    logic reset = 1'b1;

    exec_controller_if bus();

    exec_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        logic        step;
        logic        run;
        logic        bpen;
        logic [31:0] instr;
        int          cycles;
        int          pulses;
        logic        running;
        logic        halted;
        logic [31:0] retired;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.step_btn = 1'b0;
        bus.run_sw   = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = BPA;
        bus.pc       = 32'd0;
        bus.instr    = NOP;
        @(posedge clk);
        @(negedge clk);
        check("rst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        check("rst_running", {31'd0, bus.running}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        reset = 1'b0;
    endtask

    // Advances n cycles, sampling at negedges; the core PC advances on each retire.
    task automatic run_cycles(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.cpu_en) begin
                pulses++;
                if (first == 0) first = i;
                bus.pc = bus.pc + 32'd4;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first;
        int found;
        int first_run;
        int first_en;

        // rst step run bpen instr cycles pulses running halted retired
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, NOP, 2,  0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP, 2,  0, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 2,  0, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP, 2,  0, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP, 10, 0, 1'b0, 1'b0, 32'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, NOP, 3,  0, 1'b1, 1'b0, 32'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, NOP, 16, 5, 1'b1, 1'b0, 32'd5};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP, 6,  1, 1'b0, 1'b0, 32'd6};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP, 6,  0, 1'b0, 1'b0, 32'd6};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, NOP, 3,  0, 1'b1, 1'b0, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, NOP, 16, 3, 1'b0, 1'b1, 32'd3};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, NOP, 10, 2, 1'b1, 1'b0, 32'd4};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, NOP, 6,  2, 1'b1, 1'b0, 32'd6};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, EBK, 3,  0, 1'b1, 1'b0, 32'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, EBK, 6,  0, 1'b0, 1'b1, 32'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, EBK, 6,  0, 1'b0, 1'b0, 32'd0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, EBK, 10, 1, 1'b0, 1'b0, 32'd1};

        bus.step_btn = 1'b0;
        bus.run_sw   = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = BPA;
        bus.pc       = 32'd0;
        bus.instr    = NOP;

        // Clean press: one pulse, 2 + DEB + 1 cycles after the press.
        do_reset();
        bus.step_btn = 1'b1;
        run_cycles(20, pulses, first);
        check("s1_pulses", pulses, 1);
        check("s1_latency", first, 2 + DEB + 1);
        check("s1_retired", bus.retired, 32'd1);
        check("s1_running", {31'd0, bus.running}, 32'd0);
        check("s1_halted", {31'd0, bus.halted}, 32'd0);
        bus.step_btn = 1'b0;
        run_cycles(10, pulses, first);
        check("s1_release_pulses", pulses, 0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst) do_reset();
            bus.step_btn = vecs[i].step;
            bus.run_sw   = vecs[i].run;
            bus.bp_en    = vecs[i].bpen;
            bus.instr    = vecs[i].instr;
            run_cycles(vecs[i].cycles, pulses, first);
            check($sformatf("v%0d_pulses", i), pulses, vecs[i].pulses);
            check($sformatf("v%0d_running", i), {31'd0, bus.running}, {31'd0, vecs[i].running});
            check($sformatf("v%0d_halted", i), {31'd0, bus.halted}, {31'd0, vecs[i].halted});
            check($sformatf("v%0d_retired", i), bus.retired, vecs[i].retired);
        end

        // Asynchronous reset in the middle of a pulse, then re-entry into RUN.
        do_reset();
        bus.run_sw = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.cpu_en && bus.retired == 32'd7) found = 1;
        end
        check("s6_found_pulse", found, 1);
        reset = 1'b1;
        #1;
        check("s6_async_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        check("s6_async_retired", bus.retired, 32'd0);
        check("s6_async_running", {31'd0, bus.running}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        first_run = 0;
        first_en  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.running && first_run == 0) first_run = i;
            if (bus.cpu_en && first_en == 0) first_en = i;
        end
        check("s6_reenter_run", first_run, 3);
        check("s6_first_pulse", first_en, 3 + DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
